mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute result held in the EX/MEM latch: rd address/data, write flag, effective address, command type, and store data.
- Performs loads and stores through a level-handshake request to the memory controller. Raises a stall while an access is outstanding.
- Delivers a registered writeback bundle plus a combinational forward path back to ID.

Parameters:
CMD_W, 6, width of command-type bus (matches Cmd_Typebus)
XLEN, 32, register/data/address width

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes all state
cmdtype_in  input  CMD_W  command type from EX/MEM latch
rsd_addr_in  input  5  destination register (valid for loads too)
rsd_data_in  input  XLEN  ALU result from EX
write_rsd_in  input  1  EX write-enable for non-memory ops
mem_addr_in  input  XLEN  effective address
store_data_in  input  XLEN  rs2 value for stores
mem_req_o  output  1  request to memory controller (level)
mem_we_o  output  1  1=store, 0=load
mem_addr_o  output  XLEN  access address
mem_len_o  output  2  bytes-1 (0=byte,1=half,3=word)
mem_wdata_o  output  XLEN  store data, low-aligned
mem_done_i  input  1  one-cycle completion pulse from controller
mem_rdata_i  input  XLEN  load data, low-aligned, valid with done
stall_req_o  output  1  hold upstream pipeline
wb_we_o  output  1  registered writeback enable
wb_addr_o  output  5  registered writeback register
wb_data_o  output  XLEN  registered writeback data
mem_forward_o  output  1  combinational forward valid
mem_forward_addr_o  output  5  forward register
mem_forward_data_o  output  XLEN  forward data

Behaviour:
- Reset (rst_in=1 at clk edge) overrides all other inputs:
  - state<=IDLE.
  - wb_we_o/wb_addr_o/wb_data_o<=0.
  - mem_req_o=0.
  - Applies mid-access too: the request drops and any later mem_done_i is ignored until a new request.
- Command classes use codebase command codes:
  - LOAD = CmdLB, CmdLH, CmdLW, CmdLBU, CmdLHU.
  - STORE = CmdSB, CmdSH, CmdSW.
  - Everything else = non-memory.
- FSM states IDLE and WAIT.
  - IDLE: if rdy_in and cmdtype is LOAD/STORE -> WAIT; otherwise stay.
  - WAIT: if rdy_in and mem_done_i -> IDLE; otherwise stay.
- Memory request outputs:
  - mem_req_o = 1 in WAIT only. The request starts the cycle after the command arrives.
  - mem_we_o, mem_addr_o, mem_len_o and mem_wdata_o are driven from the current inputs whenever mem_req_o=1, else 0.
  - Inputs stay stable because upstream is stalled.
  - mem_len_o: B/BU=0, H/HU=1, W=3.
  - mem_wdata_o: store_data_in masked to the access width.
- stall_req_o (combinational) = mem op present AND NOT (state==WAIT AND mem_done_i). Stall drops in the done cycle, so the next instruction enters on that edge.
- Load data extension, applied to mem_rdata_i:
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: pass through.
- Writeback register, updated each edge with rdy_in=1:
  - Non-mem op: wb_we_o <= write_rsd_in && rsd_addr_in!=0; wb_addr_o <= rsd_addr_in; wb_data_o <= rsd_data_in.
  - LOAD completing (WAIT && mem_done_i): wb_we_o <= rsd_addr_in!=0; wb_data_o <= extended data.
  - STORE completing, any IDLE mem-op arrival, or WAIT without done: wb_we_o <= 0 (bubble); addr/data <= 0.
- rdy_in=0: state and wb registers hold. mem_req_o holds, since it is state-derived.
- Forwarding (combinational):
  - Non-mem: mem_forward_o = write_rsd_in && rsd_addr_in!=0, with rsd_data_in.
  - LOAD: valid only in the done cycle, with extended data.
  - STORE: 0.
  - Forward address is rsd_addr_in whenever valid, else 0.
- Latency:
  - Non-mem op: 1 cycle to wb.
  - Memory op: 1 + controller latency + 1. Minimum 2 cycles stall when done arrives in the first WAIT cycle.
- mem_done_i in IDLE is ignored.
- Back-to-back memory ops re-enter WAIT with one IDLE cycle between requests.

Test Plan:
- LW, addr 0x100, rd=5; done pulses 3 cycles after req with rdata 0xDEADBEEF:
  - stall_req_o high until the done cycle; forward valid only in the done cycle.
  - Next edge: wb_we_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF.
- LB/LBU with rdata 0x00000080 -> wb_data_o 0xFFFFFF80 / 0x00000080. LH with 0x0000F00F -> 0xFFFFF00F.
- SH, addr 0x204, store_data 0x1234ABCD:
  - mem_we_o=1, mem_len_o=1, mem_wdata_o=0x0000ABCD.
  - After done, wb_we_o=0 and no forward.
- ADD result 7, rd=3, write_rsd_in=1 -> stall_req_o=0, forward (3,7) same cycle, wb (1,3,7) next edge. Same with rd=0 -> wb_we_o=0, no forward.
- rst_in asserted in WAIT before done -> next cycle state IDLE, mem_req_o=0, wb outputs 0; a late done is ignored.
- rdy_in low for 2 cycles during WAIT while done pulses -> done ignored; FSM stays WAIT; wb outputs hold.

Source files
------------

// File: rtl/mem_stage_if.sv
// Memory-controller bus between the memory-access stage and the memory
// controller: a level request with access attributes, and a one-cycle
// completion pulse carrying load data.
interface mem_stage_if #(
   parameter int XLEN = 32
);
   logic            mem_req_o;
   logic            mem_we_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [1:0]      mem_len_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic            mem_done_i;
   logic [XLEN-1:0] mem_rdata_i;

   // Pipeline stage side: issues requests, receives completion.
   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_wdata_o,
      input  mem_done_i, mem_rdata_i
   );

   // Memory controller side.
   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_len_o, mem_wdata_o,
      output mem_done_i, mem_rdata_i
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores to the memory controller, stalls
// upstream while an access is outstanding, and produces the registered
// writeback bundle plus a combinational forward path back to decode.
module mem_stage #(
   parameter int CMD_W = 6,
   parameter int XLEN  = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic [CMD_W-1:0] cmdtype_in,
   input  logic [4:0]       rsd_addr_in,
   input  logic [XLEN-1:0]  rsd_data_in,
   input  logic             write_rsd_in,
   input  logic [XLEN-1:0]  mem_addr_in,
   input  logic [XLEN-1:0]  store_data_in,
   mem_stage_if.master      bus,
   output logic             stall_req_o,
   output logic             wb_we_o,
   output logic [4:0]       wb_addr_o,
   output logic [XLEN-1:0]  wb_data_o,
   output logic             mem_forward_o,
   output logic [4:0]       mem_forward_addr_o,
   output logic [XLEN-1:0]  mem_forward_data_o
);

   // Command codes shared with the decoder's command-type bus.
   localparam logic [CMD_W-1:0] CMD_LB  = CMD_W'(11);
   localparam logic [CMD_W-1:0] CMD_LH  = CMD_W'(12);
   localparam logic [CMD_W-1:0] CMD_LW  = CMD_W'(13);
   localparam logic [CMD_W-1:0] CMD_LBU = CMD_W'(14);
   localparam logic [CMD_W-1:0] CMD_LHU = CMD_W'(15);
   localparam logic [CMD_W-1:0] CMD_SB  = CMD_W'(16);
   localparam logic [CMD_W-1:0] CMD_SH  = CMD_W'(17);
   localparam logic [CMD_W-1:0] CMD_SW  = CMD_W'(18);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t          state, state_nxt;
   logic            is_load, is_store, is_mem;
   logic            done_acc;
   logic [1:0]      len;
   logic [XLEN-1:0] load_data;

   // Access size encoded as bytes-1.
   function automatic logic [1:0] access_len(input logic [CMD_W-1:0] cmd);
      case (cmd)
         CMD_LB, CMD_LBU, CMD_SB: access_len = 2'd0;
         CMD_LH, CMD_LHU, CMD_SH: access_len = 2'd1;
         default:                 access_len = 2'd3;
      endcase
   endfunction

   // Sign/zero extension of low-aligned load data.
   function automatic logic [XLEN-1:0] load_extend(input logic [CMD_W-1:0] cmd,
                                                   input logic [XLEN-1:0]  rdata);
      case (cmd)
         CMD_LB:  load_extend = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
         CMD_LBU: load_extend = {{(XLEN-8){1'b0}}, rdata[7:0]};
         CMD_LH:  load_extend = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
         CMD_LHU: load_extend = {{(XLEN-16){1'b0}}, rdata[15:0]};
         default: load_extend = rdata;
      endcase
   endfunction

   // Clears store-data bits above the access width.
   function automatic logic [XLEN-1:0] width_mask(input logic [1:0]      l,
                                                  input logic [XLEN-1:0] data);
      case (l)
         2'd0:    width_mask = data & XLEN'(8'hFF);
         2'd1:    width_mask = data & XLEN'(16'hFFFF);
         default: width_mask = data;
      endcase
   endfunction

   // Classify the command held in the EX/MEM latch.
   always_comb begin
      is_load   = cmdtype_in inside {CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU};
      is_store  = cmdtype_in inside {CMD_SB, CMD_SH, CMD_SW};
      is_mem    = is_load || is_store;
      len       = access_len(cmdtype_in);
      load_data = load_extend(cmdtype_in, bus.mem_rdata_i);
      // A completion only counts while the pipeline is advancing.
      done_acc  = (state == WAIT) && bus.mem_done_i && rdy_in;
   end

   // State register; rdy_in low freezes the access sequence.
   always_ff @(posedge clk_in) begin
      if (rst_in)      state <= IDLE;
      else if (rdy_in) state <= state_nxt;
   end

   // Next-state: enter WAIT on a memory op, leave on completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (is_mem) state_nxt = WAIT;
         WAIT:    if (bus.mem_done_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request attributes come straight from the latch, which upstream holds stable.
   always_comb begin
      bus.mem_req_o   = (state == WAIT);
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_len_o   = 2'd0;
      bus.mem_wdata_o = '0;
      if (bus.mem_req_o) begin
         bus.mem_we_o    = is_store;
         bus.mem_addr_o  = mem_addr_in;
         bus.mem_len_o   = len;
         bus.mem_wdata_o = is_store ? width_mask(len, store_data_in) : '0;
      end
   end

   // Stall holds upstream until the completing cycle, so the next op enters on that edge.
   always_comb begin
      stall_req_o        = is_mem && !done_acc;
      mem_forward_o      = 1'b0;
      mem_forward_data_o = '0;
      if (!is_mem) begin
         mem_forward_o      = write_rsd_in && (rsd_addr_in != 5'd0);
         mem_forward_data_o = rsd_data_in;
      end else if (is_load && done_acc) begin
         mem_forward_o      = 1'b1;
         mem_forward_data_o = load_data;
      end
      mem_forward_addr_o = mem_forward_o ? rsd_addr_in : 5'd0;
      if (!mem_forward_o) mem_forward_data_o = '0;
   end

   // Writeback bundle: ALU results pass through, loads write on completion, else bubble.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wb_we_o   <= 1'b0;
         wb_addr_o <= '0;
         wb_data_o <= '0;
      end else if (rdy_in) begin
         if (!is_mem) begin
            wb_we_o   <= write_rsd_in && (rsd_addr_in != 5'd0);
            wb_addr_o <= rsd_addr_in;
            wb_data_o <= rsd_data_in;
         end else if (is_load && done_acc) begin
            wb_we_o   <= (rsd_addr_in != 5'd0);
            wb_addr_o <= rsd_addr_in;
            wb_data_o <= load_data;
         end else begin
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instruction stream
// checked against a transaction-level model of the stage.
module tb_mem_stage;
   localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
   localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18, ADD = 6'd1;

   logic        clk = 1'b0;
   logic        rst, rdy, write_rsd;
   logic [5:0]  cmd;
   logic [4:0]  rd;
   logic [31:0] rsd_data, maddr, sdata;
   logic        stall, wb_we, fwd;
   logic [4:0]  wb_addr, fwd_addr;
   logic [31:0] wb_data, fwd_data;
   int unsigned chk = 0;
   int unsigned err = 0;

   mem_stage_if #(.XLEN(32)) bus ();

   mem_stage #(.CMD_W(6), .XLEN(32)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .cmdtype_in(cmd),
      .rsd_addr_in(rd), .rsd_data_in(rsd_data), .write_rsd_in(write_rsd),
      .mem_addr_in(maddr), .store_data_in(sdata), .bus(bus.master),
      .stall_req_o(stall), .wb_we_o(wb_we), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
      .mem_forward_o(fwd), .mem_forward_addr_o(fwd_addr), .mem_forward_data_o(fwd_data)
   );

   always #5 clk = ~clk;

   // One non-memory op: forwarded in its own cycle, written back on the next edge.
   task automatic run_alu(input logic [5:0] c, input logic [4:0] r, input logic [31:0] d,
                          input logic w, input string tag);
      logic ev;
      ev = w && (r != 5'd0);
      cmd = c; rd = r; rsd_data = d; write_rsd = w; maddr = $urandom; sdata = $urandom;
      bus.mem_done_i = 1'b0;
      @(negedge clk);
      chk++;
      if ({stall, bus.mem_req_o, fwd, fwd_addr} !== {1'b0, 1'b0, ev, ev ? r : 5'd0}) begin
         err++;
         $display("FAIL %s alu_comb: got %b expected %b", tag,
                  {stall, bus.mem_req_o, fwd, fwd_addr}, {1'b0, 1'b0, ev, ev ? r : 5'd0});
      end
      if (ev) begin
         chk++;
         if (fwd_data !== d) begin
            err++; $display("FAIL %s alu_fwd_data: got %h expected %h", tag, fwd_data, d);
         end
      end
      @(posedge clk); #1;
      chk++;
      if ({wb_we, wb_addr, wb_data} !== {ev, r, d}) begin
         err++;
         $display("FAIL %s alu_wb: got %b/%0d/%h expected %b/%0d/%h", tag,
                  wb_we, wb_addr, wb_data, ev, r, d);
      end
   endtask

   // One memory op with a controller answering `lat` cycles after the request starts.
   task automatic run_mem_op(input logic [5:0] c, input logic [4:0] r, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rdv, input int lat,
                             input string tag);
      logic        ld, st, fv, last;
      logic [1:0]  el;
      logic [31:0] ew, ex, b;
      ld = (c == LB) || (c == LH) || (c == LW) || (c == LBU) || (c == LHU);
      st = (c == SB) || (c == SH) || (c == SW);
      el = (c == LB || c == LBU || c == SB) ? 2'd0 : (c == LH || c == LHU || c == SH) ? 2'd1 : 2'd3;
      ew = !st ? 32'd0 : (el == 2'd0) ? sd % 256 : (el == 2'd1) ? sd % 65536 : sd;
      case (c)
         LB:      begin b = rdv % 256;   ex = (b >= 128)   ? b - 32'd256   : b; end
         LBU:     begin b = rdv % 256;   ex = b; end
         LH:      begin b = rdv % 65536; ex = (b >= 32768) ? b - 32'd65536 : b; end
         LHU:     begin b = rdv % 65536; ex = b; end
         default: begin b = rdv;         ex = rdv; end
      endcase
      cmd = c; rd = r; rsd_data = $urandom; write_rsd = 1'($urandom_range(0, 1));
      maddr = a; sdata = sd; bus.mem_done_i = 1'b0;
      @(negedge clk);
      chk++;
      if ({stall, bus.mem_req_o, fwd} !== 3'b100) begin
         err++; $display("FAIL %s arrive: got %b expected 100", tag, {stall, bus.mem_req_o, fwd});
      end
      @(posedge clk); #1;
      chk++;
      if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
         err++; $display("FAIL %s arrive_wb: got %b/%0d/%h expected 0", tag, wb_we, wb_addr, wb_data);
      end
      for (int k = 0; k <= lat; k++) begin
         last = (k == lat);
         bus.mem_done_i = last;
         bus.mem_rdata_i = last ? rdv : $urandom;
         @(negedge clk);
         chk++;
         if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_len_o} !== {1'b1, st, a, el}) begin
            err++;
            $display("FAIL %s req: got %b/%b/%h/%0d expected 1/%b/%h/%0d", tag, bus.mem_req_o,
                     bus.mem_we_o, bus.mem_addr_o, bus.mem_len_o, st, a, el);
         end
         if (st) begin
            chk++;
            if (bus.mem_wdata_o !== ew) begin
               err++; $display("FAIL %s wdata: got %h expected %h", tag, bus.mem_wdata_o, ew);
            end
         end
         fv = last && ld;
         chk++;
         if ({stall, fwd, fwd_addr} !== {!last, fv, fv ? r : 5'd0}) begin
            err++;
            $display("FAIL %s stall_fwd: got %b expected %b", tag, {stall, fwd, fwd_addr},
                     {!last, fv, fv ? r : 5'd0});
         end
         if (fv) begin
            chk++;
            if (fwd_data !== ex) begin
               err++; $display("FAIL %s fwd_data: got %h expected %h", tag, fwd_data, ex);
            end
         end
         @(posedge clk); #1;
         bus.mem_done_i = 1'b0;
         chk++;
         if (!last && {wb_we, wb_addr, wb_data} !== 38'd0) begin
            err++; $display("FAIL %s wait_wb: got %b/%0d/%h expected 0", tag, wb_we, wb_addr, wb_data);
         end else if (last && {wb_we, wb_addr, wb_data} !== {ld && r != 5'd0, ld ? r : 5'd0, ld ? ex : 32'd0}) begin
            err++;
            $display("FAIL %s done_wb: got %b/%0d/%h expected %b/%0d/%h", tag, wb_we, wb_addr,
                     wb_data, ld && r != 5'd0, ld ? r : 5'd0, ld ? ex : 32'd0);
         end
      end
      chk++;
      if (bus.mem_req_o !== 1'b0) begin
         err++; $display("FAIL %s req_after: got %b expected 0", tag, bus.mem_req_o);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      chk++;
      if ({wb_we, wb_addr, wb_data, bus.mem_req_o, stall} !== 40'd0) begin
         err++; $display("FAIL reset_state: got %b/%0d/%h req %b stall %b expected 0",
                         wb_we, wb_addr, wb_data, bus.mem_req_o, stall);
      end
      rst = 1'b0;
      run_alu(ADD, 5'd4, 32'hAB, 1'b1, "pre_reset");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk++;
      if ({wb_we, wb_addr, wb_data} !== 38'd0) begin
         err++; $display("FAIL reset_override: got %b/%0d/%h expected 0", wb_we, wb_addr, wb_data);
      end
   endtask

   task automatic test_lw();
      run_mem_op(LW, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 3, "lw");
   endtask

   task automatic test_load_ext();
      run_mem_op(LB,  5'd7, 32'h10, 32'h0, 32'h00000080, 0, "lb");
      run_mem_op(LBU, 5'd8, 32'h11, 32'h0, 32'h00000080, 1, "lbu");
      run_mem_op(LH,  5'd9, 32'h12, 32'h0, 32'h0000F00F, 0, "lh");
      run_mem_op(LHU, 5'd0, 32'h14, 32'h0, 32'h0000F00F, 2, "lhu_r0");
   endtask

   task automatic test_store();
      run_mem_op(SH, 5'd2, 32'h204, 32'h1234ABCD, 32'h0, 1, "sh");
      run_mem_op(SB, 5'd2, 32'h207, 32'h1234ABCD, 32'h0, 0, "sb");
   endtask

   task automatic test_alu();
      run_alu(ADD, 5'd3, 32'd7, 1'b1, "add_r3");
      run_alu(ADD, 5'd0, 32'd7, 1'b1, "add_r0");
      run_alu(ADD, 5'd6, 32'd9, 1'b0, "add_nowr");
   endtask

   task automatic test_reset_mid_access();
      cmd = LW; rd = 5'd6; maddr = 32'h300; write_rsd = 1'b0; bus.mem_done_i = 1'b0;
      @(posedge clk); #1;
      chk++;
      if (bus.mem_req_o !== 1'b1) begin
         err++; $display("FAIL rstmid_req: got %b expected 1", bus.mem_req_o);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk++;
      if ({bus.mem_req_o, wb_we, wb_addr, wb_data} !== 39'd0) begin
         err++; $display("FAIL rstmid_after: got req %b wb %b/%0d/%h expected 0",
                         bus.mem_req_o, wb_we, wb_addr, wb_data);
      end
      bus.mem_done_i = 1'b1; bus.mem_rdata_i = 32'h11;
      @(negedge clk);
      chk++;
      if ({stall, fwd} !== 2'b10) begin
         err++; $display("FAIL rstmid_late_done: got %b expected 10", {stall, fwd});
      end
      @(posedge clk); #1;
      bus.mem_done_i = 1'b0;
      chk++;
      if ({wb_we, bus.mem_req_o} !== 2'b01) begin
         err++; $display("FAIL rstmid_rerequest: got %b expected 01", {wb_we, bus.mem_req_o});
      end
      bus.mem_done_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
      @(posedge clk); #1;
      bus.mem_done_i = 1'b0;
      chk++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd6, 32'h12345678}) begin
         err++; $display("FAIL rstmid_wb: got %b/%0d/%h expected 1/6/12345678", wb_we, wb_addr, wb_data);
      end
   endtask

   task automatic test_rdy_low();
      run_alu(ADD, 5'd9, 32'h55, 1'b1, "rdy_pre");
      rdy = 1'b0;
      cmd = LW; rd = 5'd10; maddr = 32'h400; bus.mem_done_i = 1'b0;
      @(posedge clk); #1;
      chk++;
      if ({wb_we, wb_addr, wb_data, bus.mem_req_o} !== {1'b1, 5'd9, 32'h55, 1'b0}) begin
         err++; $display("FAIL rdy_hold_idle: got %b/%0d/%h req %b expected 1/9/55 req 0",
                         wb_we, wb_addr, wb_data, bus.mem_req_o);
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0; bus.mem_done_i = 1'b1; bus.mem_rdata_i = 32'h77;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk++;
         if ({bus.mem_req_o, wb_we, wb_addr, wb_data} !== 39'h4000000000) begin
            err++; $display("FAIL rdy_hold_wait: got req %b wb %b/%0d/%h expected 1 0/0/0",
                            bus.mem_req_o, wb_we, wb_addr, wb_data);
         end
      end
      rdy = 1'b1; bus.mem_done_i = 1'b0;
      @(negedge clk);
      chk++;
      if ({bus.mem_req_o, stall} !== 2'b11) begin
         err++; $display("FAIL rdy_still_wait: got %b expected 11", {bus.mem_req_o, stall});
      end
      @(posedge clk); #1;
      bus.mem_done_i = 1'b1; bus.mem_rdata_i = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.mem_done_i = 1'b0;
      chk++;
      if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd10, 32'hCAFEF00D}) begin
         err++; $display("FAIL rdy_resume_wb: got %b/%0d/%h expected 1/10/cafef00d", wb_we, wb_addr, wb_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] mops [8];
      logic [5:0] c;
      mops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
      run_mem_op(LW, 5'd1, 32'h40, 32'h0, 32'h01020304, 0, "b2b_lw");
      run_mem_op(SW, 5'd1, 32'h44, 32'hA5A5A5A5, 32'h0, 0, "b2b_sw");
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 6) begin
            run_mem_op(mops[$urandom_range(0, 7)], 5'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), "rand_mem");
         end else begin
            do c = 6'($urandom); while (c inside {LB, LH, LW, LBU, LHU, SB, SH, SW});
            run_alu(c, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
                    1'($urandom_range(0, 1)), "rand_alu");
         end
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; cmd = 6'd0; rd = 5'd0; rsd_data = 32'd0; write_rsd = 1'b0;
      maddr = 32'd0; sdata = 32'd0; bus.mem_done_i = 1'b0; bus.mem_rdata_i = 32'd0;
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_alu();
      test_reset_mid_access();
      test_rdy_low();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule
